// File: rtl/voting_if.sv
// voting_if: vote vector in, registered decision/count/tie out
interface voting_if #(parameter int N_VOTERS = 4);
  logic [N_VOTERS-1:0] inp;
  logic out;
  logic [$clog2(N_VOTERS+1)-1:0] count;
  logic tie;
  modport master (output inp, input out, count, tie);
  modport slave (input inp, output out, count, tie);
endinterface

// File: rtl/voting.sv
// voting: registered majority vote with popcount, tie flag and optional chair tie-break
module voting #(
  parameter int N_VOTERS = 4,
  parameter bit TIE_CHAIR = 1'b1
) (
  input logic clk,
  input logic rst_n,
  voting_if.slave bus
);
  localparam int CW = $clog2(N_VOTERS+1);
  localparam logic [CW-1:0] HALF = CW'(N_VOTERS/2);
  logic [CW-1:0] ones;
  logic is_tie, pass;
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_VOTERS; i++) ones = ones + CW'(bus.inp[i]);
  end
  // an odd panel can never split evenly
  assign is_tie = (N_VOTERS % 2 == 0) && (ones == HALF);
  assign pass = (ones > HALF) || (is_tie && TIE_CHAIR && bus.inp[N_VOTERS-1]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out <= 1'b0;
      bus.count <= '0;
      bus.tie <= 1'b0;
    end else begin
      bus.out <= pass;
      bus.count <= ones;
      bus.tie <= is_tie;
    end
  end
endmodule

// File: tb/tb_voting.sv
// tb_voting: directed vectors on three configurations checked against a behavioural model
module tb_voting;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] stim = 5'b0;
  logic [4:0] last = 5'b0;
  logic have = 1'b0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  voting_if #(4) b4c ();
  voting_if #(4) b4n ();
  voting_if #(5) b5 ();
  assign b4c.inp = stim[3:0];
  assign b4n.inp = stim[3:0];
  assign b5.inp = stim;

  voting #(.N_VOTERS(4), .TIE_CHAIR(1'b1)) u4c (.clk(clk), .rst_n(rst_n), .bus(b4c));
  voting #(.N_VOTERS(4), .TIE_CHAIR(1'b0)) u4n (.clk(clk), .rst_n(rst_n), .bus(b4n));
  voting #(.N_VOTERS(5), .TIE_CHAIR(1'b1)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // returns {out, tie, count} from counting yes votes
  function automatic logic [4:0] model(input int n, input bit tc, input logic [4:0] v);
    int c;
    bit t, o;
    c = 0;
    for (int i = 0; i < n; i++) c += int'(v[i]);
    t = (n % 2 == 0) && (2 * c == n);
    o = (2 * c > n) || (t && tc && v[n-1]);
    return {o, t, 3'(c)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) have <= 1'b0;
    else begin
      have <= 1'b1;
      last <= stim;
    end
  end

  task automatic cmp(input string nm, input int n, input bit tc, input logic o, input logic t, input logic [2:0] c);
    logic [4:0] e;
    e = have ? model(n, tc, last) : 5'b0;
    chk({nm, ".out"}, int'(o), int'(e[4]));
    chk({nm, ".tie"}, int'(t), int'(e[3]));
    chk({nm, ".count"}, int'(c), int'(e[2:0]));
  endtask

  always @(negedge clk) begin
    cmp("n4c", 4, 1'b1, b4c.out, b4c.tie, b4c.count);
    cmp("n4n", 4, 1'b0, b4n.out, b4n.tie, b4n.count);
    cmp("n5", 5, 1'b1, b5.out, b5.tie, b5.count);
  end

  task automatic step(input logic [4:0] v);
    @(negedge clk);
    #2 stim = v;
  endtask

  initial begin
    stim = 5'b01111;
    repeat (3) step(5'b01111);
    chk("rst_out", int'(b4c.out), 0);
    chk("rst_count", int'(b4c.count), 0);
    chk("rst_tie", int'(b4c.tie), 0);
    rst_n = 1'b1;
    step(5'b01111);
    chk("rel_out", int'(b4c.out), 1);
    chk("rel_count", int'(b4c.count), 4);
    for (int v = 0; v < 16; v++) step(5'(v));
    for (int v = 0; v < 32; v++) step(5'(v));
    step(5'b00011);
    step(5'b00111);
    chk("0011_count", int'(b4c.count), 2);
    chk("0011_tie", int'(b4c.tie), 1);
    chk("0011_out", int'(b4c.out), 0);
    step(5'b01100);
    chk("0111_count", int'(b4c.count), 3);
    chk("0111_out", int'(b4c.out), 1);
    step(5'b00000);
    chk("1100_chair_out", int'(b4c.out), 1);
    chk("1100_chair_tie", int'(b4c.tie), 1);
    chk("1100_nochair_out", int'(b4n.out), 0);
    chk("1100_nochair_tie", int'(b4n.tie), 1);
    step(5'b00000);
    chk("zero_out", int'(b4c.out), 0);
    chk("zero_count", int'(b4c.count), 0);
    step(5'b01110);
    chk("lat_before", int'(b4c.out), 0);
    step(5'b00000);
    chk("lat_high", int'(b4c.out), 1);
    step(5'b00000);
    chk("lat_after", int'(b4c.out), 0);
    step(5'b01111);
    step(5'b01111);
    chk("hold_count", int'(b4c.count), 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", int'(b4c.out), 0);
    chk("async_count", int'(b4c.count), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("post_rst_out", int'(b4c.out), 1);
    chk("post_rst_count", int'(b4c.count), 4);
    step(5'b00111);
    step(5'b00011);
    chk("n5_00111_count", int'(b5.count), 3);
    chk("n5_00111_out", int'(b5.out), 1);
    chk("n5_00111_tie", int'(b5.tie), 0);
    step(5'b11111);
    chk("n5_00011_count", int'(b5.count), 2);
    chk("n5_00011_out", int'(b5.out), 0);
    chk("n5_00011_tie", int'(b5.tie), 0);
    step(5'b00000);
    chk("n5_all_count", int'(b5.count), 5);
    chk("n5_all_out", int'(b5.out), 1);
    step(5'b00000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
